sar_logic: RTL and testbench

Successive-approximation control block for the tiny-SAR ADC: consumes the sample and SAR step clocks produced by the clock generator, drives the S/H track enable and the capacitive DAC code, reads the comparator, and emits one N-bit conversion result per sample frame. It is the downstream consumer of `clk_out_sample` / `clk_out_sar`. Everything runs in the single 2 MHz `clk` domain; both incoming clocks are treated as synchronous levels and rising-edge detected internally.

---
 rtl/sar_logic.sv | 124 ++++++++++++
 tb/tb_sar_logic.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sar_logic.sv
// Successive-approximation controller: sample/hold sequencing, binary-search DAC trial codes, result capture.
// Optional macro SAR_OVERRUN_EN: a sample edge mid-conversion aborts it and raises a sticky overrun flag.
`timescale 1ns/1ps
module sar_logic #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_clk,
  input  logic         sar_clk,
  input  logic         comp_in,
  output logic         sample_en,
  output logic [N-1:0] dac_code,
  output logic         busy,
  output logic [N-1:0] data_out,
  output logic         data_valid
`ifdef SAR_OVERRUN_EN
  ,
  output logic         overrun
`endif
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT} state_t;

  state_t          state, state_n;
  logic            sample_q, sar_q;
  logic            s_rise, t_rise;
  logic [IW-1:0]   bit_idx, idx_n;
  logic [N-1:0]    dac_n, dout_n;
  logic            sample_en_n, dv_n;
`ifdef SAR_OVERRUN_EN
  logic            ovr_n;
`endif

  // Edge-history flops reset high so a level already high at reset release is not an edge.
  assign s_rise = sample_clk & ~sample_q;
  assign t_rise = sar_clk & ~sar_q;

  always_comb begin
    state_n     = state;
    sample_en_n = sample_en;
    dac_n       = dac_code;
    idx_n       = bit_idx;
    dout_n      = data_out;
    dv_n        = 1'b0;
`ifdef SAR_OVERRUN_EN
    ovr_n       = overrun;
`endif
    case (state)
      IDLE: begin
        sample_en_n = 1'b0;
        if (s_rise) begin
          state_n     = SAMPLE;
          sample_en_n = 1'b1;
        end
      end
      SAMPLE: begin
        if (s_rise) begin
          sample_en_n = 1'b1;
        end else if (t_rise) begin
          sample_en_n = 1'b0;
          dac_n       = N'(1) << (N-1);
          idx_n       = IW'(N-1);
          state_n     = CONVERT;
        end
      end
      CONVERT: begin
`ifdef SAR_OVERRUN_EN
        if (s_rise) begin
          state_n     = SAMPLE;
          sample_en_n = 1'b1;
          ovr_n       = 1'b1;
        end else
`endif
        if (t_rise) begin
          dac_n[bit_idx] = comp_in;
          if (bit_idx != '0) begin
            dac_n[bit_idx - 1'b1] = 1'b1;
            idx_n                 = bit_idx - 1'b1;
          end else begin
            dout_n  = dac_n;
            dv_n    = 1'b1;
            state_n = IDLE;
`ifdef SAR_OVERRUN_EN
            ovr_n   = 1'b0;
`endif
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_q   <= 1'b1;
      sar_q      <= 1'b1;
      sample_en  <= 1'b0;
      dac_code   <= '0;
      bit_idx    <= '0;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
`ifdef SAR_OVERRUN_EN
      overrun    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      sample_q   <= sample_clk;
      sar_q      <= sar_clk;
      sample_en  <= sample_en_n;
      dac_code   <= dac_n;
      bit_idx    <= idx_n;
      busy       <= (state_n != IDLE);
      data_out   <= dout_n;
      data_valid <= dv_n;
`ifdef SAR_OVERRUN_EN
      overrun    <= ovr_n;
`endif
    end
  end
endmodule

// File: tb/tb_sar_logic.sv
// Self-checking bench for sar_logic: vector table of conversions plus reset, collision and overrun sequences.
`timescale 1ns/1ps
module tb_sar_logic;
  localparam int N = 8;

  logic         clk = 1'b0, rst_n = 1'b0, sample_clk = 1'b0, sar_clk = 1'b0;
  logic         comp_in, sample_en, busy, data_valid;
  logic [N-1:0] dac_code, data_out;
`ifdef SAR_OVERRUN_EN
  logic         overrun;
`endif

  logic [N-1:0] vin  = '0;
  int           mode = 0;   // 0: comparator model, 1: comp held 0, 2: comp held 1
  int           checks = 0, errors = 0;
  logic [N-1:0] exp_q[$];
  logic         prev_v = 1'b0;

  typedef struct {
    logic [N-1:0] vin;
    int           mode;
    logic [N-1:0] exp;
  } vec_t;
  vec_t vecs[7];
  logic [N-1:0] dac_seq[8];

  always #250 clk = ~clk;

  assign comp_in = (mode == 0) ? (vin >= dac_code) : (mode == 2);

  sar_logic #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .sar_clk(sar_clk), .comp_in(comp_in),
    .sample_en(sample_en), .dac_code(dac_code), .busy(busy), .data_out(data_out),
    .data_valid(data_valid)
`ifdef SAR_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard side: every data_valid pops one expected result.
  task automatic observe();
    if (data_valid) begin
      if (exp_q.size() == 0) chk("unexpected_valid", {31'b0, data_valid}, 32'd0);
      else chk("data_out", {24'b0, data_out}, {24'b0, exp_q.pop_front()});
      chk("valid_width", {31'b0, prev_v}, 32'd0);
    end
    prev_v = data_valid;
  endtask

  task automatic cyc(input logic s, input logic t);
    sample_clk = s;
    sar_clk    = t;
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic do_samp(); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); endtask
  task automatic do_sar();  cyc(1'b0, 1'b1); cyc(1'b0, 1'b0); endtask

  task automatic conv(input logic [N-1:0] v, input int m, input logic [N-1:0] e);
    vin  = v;
    mode = m;
    exp_q.push_back(e);
    do_samp();
    chk("samp_en_track", {31'b0, sample_en}, 32'd1);
    chk("busy_sample", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      chk("busy_conv", {31'b0, busy}, 32'd1);
      do_sar();
    end
    chk("drained", exp_q.size(), 32'd0);
    chk("busy_idle", {31'b0, busy}, 32'd0);
    chk("samp_en_idle", {31'b0, sample_en}, 32'd0);
  endtask

  initial begin
    logic [N-1:0] d0;
    vecs[0] = '{8'hA5, 0, 8'hA5};
    vecs[1] = '{8'h00, 1, 8'h00};
    vecs[2] = '{8'h00, 2, 8'hFF};
    vecs[3] = '{8'h01, 0, 8'h01};
    vecs[4] = '{8'h80, 0, 8'h80};
    vecs[5] = '{8'h00, 0, 8'h00};
    vecs[6] = '{8'hFF, 0, 8'hFF};
    dac_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    // Reset state
    #600;
    chk("rst_sample_en", {31'b0, sample_en}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_dac", {24'b0, dac_code}, 32'd0);
    chk("rst_data_out", {24'b0, data_out}, 32'd0);
    chk("rst_valid", {31'b0, data_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);

    // Hand sequence: DAC trial codes for Vin = 0xA5
    vin  = 8'hA5;
    mode = 0;
    exp_q.push_back(8'hA5);
    do_samp();
    for (int i = 0; i < 9; i++) begin
      do_sar();
      if (i == 0) chk("hold_samp_en", {31'b0, sample_en}, 32'd0);
      if (i < 8) chk("dac_seq", {24'b0, dac_code}, {24'b0, dac_seq[i]});
    end
    chk("a5_drained", exp_q.size(), 32'd0);
    chk("a5_final_dac", {24'b0, dac_code}, 32'hA5);

    foreach (vecs[i]) conv(vecs[i].vin, vecs[i].mode, vecs[i].exp);

    // Sample and step edges collide while in SAMPLE
    vin  = 8'h37;
    mode = 0;
    exp_q.push_back(8'h37);
    do_samp();
    d0 = dac_code;
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    chk("coll_samp_en", {31'b0, sample_en}, 32'd1);
    chk("coll_busy", {31'b0, busy}, 32'd1);
    chk("coll_dac", {24'b0, dac_code}, {24'b0, d0});
    for (int i = 0; i < 9; i++) do_sar();
    chk("coll_drained", exp_q.size(), 32'd0);

    // Reset after the 4th trial step discards the partial result
    vin = 8'h5A;
    do_samp();
    for (int i = 0; i < 5; i++) do_sar();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_sample_en", {31'b0, sample_en}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_dac", {24'b0, dac_code}, 32'd0);
    chk("mid_rst_data_out", {24'b0, data_out}, 32'd0);
    chk("mid_rst_valid", {31'b0, data_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    prev_v = 1'b0;
    for (int i = 0; i < 9; i++) do_sar();
    chk("post_rst_idle", {31'b0, busy}, 32'd0);
    conv(8'h5A, 0, 8'h5A);

    // Sample edge after the 3rd trial step
    vin = 8'h3C;
`ifdef SAR_OVERRUN_EN
    do_samp();
    for (int i = 0; i < 4; i++) do_sar();
    do_samp();
    chk("ovr_set", {31'b0, overrun}, 32'd1);
    chk("ovr_samp_en", {31'b0, sample_en}, 32'd1);
    chk("ovr_data_kept", {24'b0, data_out}, 32'h5A);
    chk("ovr_busy", {31'b0, busy}, 32'd1);
    conv(8'hC3, 0, 8'hC3);
    chk("ovr_cleared", {31'b0, overrun}, 32'd0);
`else
    exp_q.push_back(8'h3C);
    do_samp();
    for (int i = 0; i < 4; i++) do_sar();
    do_samp();
    chk("ign_samp_en", {31'b0, sample_en}, 32'd0);
    chk("ign_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 5; i++) do_sar();
    chk("ign_drained", exp_q.size(), 32'd0);
    chk("ign_data", {24'b0, data_out}, 32'h3C);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    chk("ign_samp_en_idle", {31'b0, sample_en}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
